// File: rtl/timestamp_capture.sv
// Timestamp capture: synchronises an async event line, latches the live timestamp on
// each rising edge into a FWFT FIFO drained over an AXI-Stream style master port.
// Optional: define TIMESTAMP_CAPTURE_LATENCY_COMP_EN to back out the synchroniser delay.
module timestamp_capture #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int FIFO_DEPTH      = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  input  logic [TIMESTAMP_WIDTH-1:0]       timestamp,
  input  logic                             event_in,
  output logic [TIMESTAMP_WIDTH-1:0]       m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [SYNC_STAGES-1:0]     r_sync;
  logic                       r_sync_prev;
  logic                       r_run_prev;
  logic [TIMESTAMP_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [LW-1:0]              r_level;
  logic                       r_overflow;

  logic                       w_edge;
  logic                       w_cap;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_wr;
  logic                       w_drop;
  logic [TIMESTAMP_WIDTH-1:0] w_ts;

  // Edge detection runs regardless of run, so a line already high at run assertion
  // has no edge left to capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_run_prev  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], event_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_run_prev  <= run;
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  assign w_cap  = w_edge & run;
  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_pop  = (r_level != '0) & m_axis_tready;
  assign w_wr   = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

`ifdef TIMESTAMP_CAPTURE_LATENCY_COMP_EN
  // Report the count at the edge where event_in was first sampled high.
  assign w_ts = timestamp - TIMESTAMP_WIDTH'(SYNC_STAGES);
`else
  assign w_ts = timestamp;
`endif

  always_ff @(posedge clk) begin
    if (!reset && w_wr) r_mem[r_wr_ptr] <= w_ts;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop)                r_overflow <= 1'b1;
      else if (run && !r_run_prev) r_overflow <= 1'b0;
    end
  end

  // Head word shown only while non-empty so an empty FIFO presents zero.
  assign m_axis_tdata  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign m_axis_tvalid = (r_level != '0);
  assign fifo_level    = r_level;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed + randomised bench for timestamp_capture against a queue-based reference model.
module tb_timestamp_capture;
  localparam int W = 64;
  localparam int DEPTH = 16;
  localparam int S = 2;
`ifdef TIMESTAMP_CAPTURE_LATENCY_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic [W-1:0]  timestamp = '0;
  logic          event_in = 1'b0;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  logic          overflow;

  timestamp_capture #(.TIMESTAMP_WIDTH(W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .run(run), .timestamp(timestamp), .event_in(event_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  logic [W-1:0] ts_base = '0;

  // Reference: queue of stored words, sticky flag, and the raw history of sampled event_in.
  logic [W-1:0] mq[$];
  bit           hist[$];
  bit           m_ovf = 1'b0;
  bit           m_prev_run = 1'b0;

  task automatic model_edge(input bit ev, input bit rn, input bit rdy, input bit rst,
                            input logic [W-1:0] ts);
    int n;
    bit rise_seen, cap, full, pop;
    n = hist.size();
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_prev_run = 1'b0;
      hist.push_back(1'b0);
      return;
    end
    // Rising edge seen at the sync output: sample S edges ago high, one before that low.
    rise_seen = (n >= S + 1) && hist[n-S] && !hist[n-S-1];
    cap  = rise_seen && rn;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (cap && (!full || pop)) mq.push_back(COMP ? ts - W'(S) : ts);
    if (cap && full && !pop) m_ovf = 1'b1;
    else if (rn && !m_prev_run) m_ovf = 1'b0;
    m_prev_run = rn;
    hist.push_back(ev);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("tvalid", W'(m_axis_tvalid), W'(mq.size() > 0));
    chk("level",  W'(fifo_level), W'(mq.size()));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("tdata", m_axis_tdata, (mq.size() > 0) ? mq[0] : '0);
  endtask

  task automatic step(input bit ev, input bit rn, input bit rdy, input bit rst = 1'b0);
    logic [W-1:0] ts;
    ts = ts_base + W'(cyc);
    event_in = ev; run = rn; m_axis_tready = rdy; reset = rst; timestamp = ts;
    @(posedge clk);
    model_edge(ev, rn, rdy, rst, ts);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [W-1:0] exp_w;
    @(negedge clk);
    // 1: reset held with event toggling
    for (int i = 0; i < 3; i++) step(i[0], 1'b1, 1'b0, 1'b1);
    chk("reset_level", W'(fifo_level), '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);

    // 2: single event; sampled edge sees ts=100
    ts_base = W'(100) - W'(cyc);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);   // write edge (ts=102)
    exp_w = COMP ? W'(100) : W'(102);
    chk("single_tvalid", W'(m_axis_tvalid), W'(1));
    chk("single_tdata", m_axis_tdata, exp_w);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    chk("single_drained", W'(fifo_level), '0);

    // 3: 20 events 4 apart with no drain, then drain, then run 0->1
    for (int e = 0; e < 20; e++) begin
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("full_level", W'(fifo_level), W'(DEPTH));
    chk("full_ovf", W'(overflow), W'(1));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    chk("drained_ovf_sticky", W'(overflow), W'(1));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", W'(overflow), W'(0));

    // 4: refill past full, then write coinciding with a single pop
    for (int e = 0; e < 17; e++) begin
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);   // edge cycle with tready
    chk("wrpop_level", W'(fifo_level), W'(DEPTH));
    chk("wrpop_ovf", W'(overflow), W'(1));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);

    // 5: event held high across run 0->1, then a fresh edge
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("held_no_cap", W'(fifo_level), '0);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("fresh_cap", W'(fifo_level), W'(1));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);

    // random phase
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) == 0) ? ~event_in : event_in,
           ($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1);

    // mid-operation reset
    for (int i = 0; i < 12; i++) step(i[1], 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("midreset_level", W'(fifo_level), '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // 6: timestamp wrap; sampled edge sees 2^64-2, write edge sees 0
    ts_base = W'(0) - W'(2) - W'(cyc);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    exp_w = COMP ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0;
    chk("wrap_tvalid", W'(m_axis_tvalid), W'(1));
    chk("wrap_tdata", m_axis_tdata, exp_w);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
